// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential 8-by-4 unsigned divider.
package divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LUT,
        ITER,
        DONE
    } state_e;

endpackage

// File: rtl/divider_if.sv
// Operand and result handshakes of the divider; slave is the divider, master is its environment.
interface divider_if;
    import divider_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  dbz;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz
    );

endinterface

// File: rtl/divider_LUT.sv
// Existing 4-bit combinational divider: z = {a / b, a % b}.
module divider_LUT
    import divider_pkg::*;
(
    input  logic [DIVISOR_W-1:0]   a,
    input  logic [DIVISOR_W-1:0]   b,
    output logic [2*DIVISOR_W-1:0] z
);

    // A zero divisor never reaches this table; the guard only keeps the output defined.
    always_comb begin
        z = {4'hF, 4'h0};
        if (b != '0) begin
            z = {a / b, a % b};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential 8-by-4 unsigned divider: zero-divisor shortcut, LUT fast path for small
// dividends, otherwise an 8-step restoring shift-subtract loop.
module divider_seq
    import divider_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);

    state_e                state_q, state_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [DIVISOR_W-1:0]  lut_a_q, lut_a_d;
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;

    logic [2*DIVISOR_W-1:0] lut_z;
    logic [DIVISOR_W:0]     iter_t;
    logic [DIVISOR_W-1:0]   iter_diff;
    logic                   iter_ge;

    divider_LUT u_lut (
        .a (lut_a_q),
        .b (divisor_q),
        .z (lut_z)
    );

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        state_d     = state_q;
        divisor_d   = divisor_q;
        lut_a_d     = lut_a_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        // Only the low nibble of the difference is kept: it is below the divisor when taken.
        iter_t    = {rem_q, dq_q[DIVIDEND_W-1]};
        iter_ge   = iter_t >= {1'b0, divisor_q};
        iter_diff = iter_t[DIVISOR_W-1:0] - divisor_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in_ready_d = 1'b0;
                    divisor_d  = bus.divisor;
                    lut_a_d    = bus.dividend[DIVISOR_W-1:0];
                    dq_d       = bus.dividend;
                    rem_d      = '0;
                    cnt_d      = '0;
                    dbz_d      = 1'b0;
                    if (bus.divisor == '0) begin
                        quotient_d  = DBZ_QUOTIENT;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (bus.dividend[DIVIDEND_W-1:DIVISOR_W] == '0) begin
                        state_d = LUT;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            LUT: begin
                quotient_d  = {4'h0, lut_z[2*DIVISOR_W-1:DIVISOR_W]};
                remainder_d = lut_z[DIVISOR_W-1:0];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            ITER: begin
                rem_d = iter_ge ? iter_diff : iter_t[DIVISOR_W-1:0];
                dq_d  = {dq_q[DIVIDEND_W-2:0], iter_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                    quotient_d  = {dq_q[DIVIDEND_W-2:0], iter_ge};
                    remainder_d = iter_ge ? iter_diff : iter_t[DIVISOR_W-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // the datapath registers are few, so all of them take the reset, not just the control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            lut_a_q     <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            lut_a_q     <= lut_a_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: directed cases, backpressure, mid-operation reset,
// then every operand pair in random order against an integer reference.
module tb_divider_seq;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
        int         acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    bit   rand_ready;
    bit   ready_cmd;
    bit   pending;

    divider_if dif ();

    divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Consumer side: out_ready either follows the test's command or toggles randomly.
    initial begin
        dif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            dif.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        int   ia = int'(a);
        int   ib = int'(b);
        if (ib == 0) begin
            e.q = 8'hFF; e.r = 4'h0; e.dbz = 1'b1; e.lat = 1;
        end else begin
            e.q = 8'(ia / ib); e.r = 4'(ia % ib); e.dbz = 1'b0;
            e.lat = (ia < 16) ? 2 : 9;
        end
        e.acc = 0;
        return e;
    endfunction

    // Monitor: each new result presentation is popped and compared, including its latency.
    initial begin
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (dif.out_valid && !pending) begin
                    pending = 1'b1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: got q=%0h r=%0h, expected none (cycle %0d)",
                                 dif.quotient, dif.remainder, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", 32'(dif.quotient), 32'(e.q));
                        check("remainder", 32'(dif.remainder), 32'(e.r));
                        check("dbz", 32'(dif.dbz), 32'(e.dbz));
                        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                end
                if (dif.out_valid && dif.out_ready) pending = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        bit   done = 1'b0;
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                e     = model(a, b);
                e.acc = cyc + 1;
                sb.push_back(e);
                done  = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 60 cycles (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = dif.out_valid;
        end
        check("out_valid_timeout", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge clk);
            empty = (sb.size() == 0) && dif.in_ready;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int perm[4096];
        n_cmp        = 0;
        n_fail       = 0;
        rand_ready   = 1'b0;
        ready_cmd    = 1'b1;
        rst_n        = 1'b0;
        dif.in_valid = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(dif.in_ready), 32'd1);
        check("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_quotient", 32'(dif.quotient), 32'd0);
        check("rst_remainder", 32'(dif.remainder), 32'd0);
        check("rst_dbz", 32'(dif.dbz), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LUT path with the in_ready timeline around the handshake.
        send(8'h0D, 4'd3);
        @(negedge clk);
        check("lut_busy_in_ready", 32'(dif.in_ready), 32'd0);
        check("lut_early_out_valid", 32'(dif.out_valid), 32'd0);
        @(negedge clk);
        check("lut_out_valid", 32'(dif.out_valid), 32'd1);
        @(negedge clk);
        check("lut_after_in_ready", 32'(dif.in_ready), 32'd1);
        check("lut_after_out_valid", 32'(dif.out_valid), 32'd0);
        @(posedge clk);
        #1;

        send(8'hC8, 4'd7);
        send(8'hFF, 4'd1);
        send(8'h05, 4'd9);
        send(8'h42, 4'd0);
        @(negedge clk);
        check("dbz_out_valid", 32'(dif.out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: result held, further operands ignored, then exactly one transfer.
        ready_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(8'h9C, 4'd5);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dif.in_valid = 1'b1;
            dif.dividend = 8'($urandom);
            dif.divisor  = 4'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(dif.out_valid), 32'd1);
            check("bp_in_ready", 32'(dif.in_ready), 32'd0);
            check("bp_quotient", 32'(dif.quotient), 32'h1F);
            check("bp_remainder", 32'(dif.remainder), 32'd1);
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        ready_cmd    = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_release_out_valid", 32'(dif.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(dif.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("bp_no_extra_queue", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the fourth ITER cycle discards the operation.
        send(8'hA5, 4'd6);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
        check("midrst_in_ready", 32'(dif.in_ready), 32'd1);
        check("midrst_quotient", 32'(dif.quotient), 32'd0);
        check("midrst_remainder", 32'(dif.remainder), 32'd0);
        check("midrst_dbz", 32'(dif.dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hA5, 4'd6);
        drain();

        // Every operand pair, shuffled, with a randomly stalling consumer.
        for (int i = 0; i < 4096; i++) perm[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j   = int'($urandom_range(0, i));
            int tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        rand_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] op = 12'(perm[i]);
            send(op[11:4], op[3:0]);
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
